// File: rtl/ysyx_20020207_regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard for RAW hazard detection.
// Optional macro YSYX_20020207_REGFILE_BYPASS_EN forwards a same-cycle write-back to the read ports.
module ysyx_20020207_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        alloc_valid,
  input  logic [ADDR_WIDTH-1:0]       alloc_addr,
  output logic                        alloc_ready,
  input  logic                        wb_valid,
  input  logic [ADDR_WIDTH-1:0]       wb_addr,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] r_rf  [DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt [DEPTH];
  logic                  r_err;

  logic w_alloc_fire;
  logic w_wb_fire;
  logic w_same;
  logic w_err_set;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_dec(input logic [CNT_WIDTH-1:0] c);
    return (c == '0) ? c : c - CNT_WIDTH'(1);
  endfunction

  assign alloc_ready  = (alloc_addr == '0) || (r_cnt[alloc_addr] != CNT_MAX);
  assign w_alloc_fire = alloc_valid && alloc_ready && (alloc_addr != '0);
  assign w_wb_fire    = wb_valid && (wb_addr != '0);
  // A reservation and its completion in the same cycle cancel out, even from a zero count.
  assign w_same       = w_alloc_fire && w_wb_fire && (alloc_addr == wb_addr);
  assign w_err_set    = w_wb_fire && !w_same && (r_cnt[wb_addr] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_wb_fire) r_rf[wb_addr] <= wb_data;
      if (!w_same) begin
        if (w_alloc_fire) r_cnt[alloc_addr] <= cnt_inc(r_cnt[alloc_addr]);
        if (w_wb_fire)    r_cnt[wb_addr]    <= cnt_dec(r_cnt[wb_addr]);
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign err = r_err;

  for (genvar g = 0; g < NREAD; g++) begin : gen_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic                  w_hit;

    assign w_ra  = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_cnt = r_cnt[w_ra];
`ifdef YSYX_20020207_REGFILE_BYPASS_EN
    assign w_hit = w_wb_fire && (wb_addr == w_ra);
`else
    assign w_hit = 1'b0;
`endif
    // On a forwarded hit the completing write no longer counts toward busy.
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = (w_ra == '0) ? '0 :
                                               w_hit        ? wb_data : r_rf[w_ra];
    assign rbusy[g] = (w_ra != '0) &&
                      (w_hit ? (w_cnt > CNT_WIDTH'(1)) : (w_cnt != '0));
  end

endmodule

// File: tb/tb_ysyx_20020207_regfile_sb.sv
// Directed self-checking bench for ysyx_20020207_regfile_sb (default parameters).
module tb_ysyx_20020207_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;

  ysyx_20020207_regfile_sb dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; alloc_valid = 1'b0; alloc_addr = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) tick();
    raddr = {5'd3, 5'd5}; alloc_addr = 5'd5; #1;
    chk("rst_rd0", rdata[31:0], 32'h0);
    chk("rst_busy", {30'd0, rbusy}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_ready", {31'd0, alloc_ready}, 32'h1);
    rst = 1'b0;
    tick();

    // reset mid-operation
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; tick();
    wb_valid = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd5; tick();
    alloc_valid = 1'b0; raddr = {5'd0, 5'd5}; #1;
    chk("t1_pre_rd", rdata[31:0], 32'h1234);
    chk("t1_pre_busy", {31'd0, rbusy[0]}, 32'h1);
    chk("t1_pre_err", {31'd0, err}, 32'h1);
    #2 rst = 1'b1; #1;
    chk("t1_rst_rd", rdata[31:0], 32'h0);
    chk("t1_rst_busy", {31'd0, rbusy[0]}, 32'h0);
    chk("t1_rst_err", {31'd0, err}, 32'h0);
    chk("t1_rst_ready", {31'd0, alloc_ready}, 32'h1);
    tick(); rst = 1'b0; tick();

    // allocate then write back r3, read on port 1
    raddr = {5'd3, 5'd0}; alloc_valid = 1'b1; alloc_addr = 5'd3; #1;
    chk("t2_c0_busy", {31'd0, rbusy[1]}, 32'h0);
    tick();
    alloc_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1 chk($sformatf("t2_c%0d_busy", c), {31'd0, rbusy[1]}, 32'h1);
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF; #1;
`ifdef YSYX_20020207_REGFILE_BYPASS_EN
    chk("t2_c4_rd", rdata[63:32], 32'hDEADBEEF);
    chk("t2_c4_busy", {31'd0, rbusy[1]}, 32'h0);
`else
    chk("t2_c4_rd", rdata[63:32], 32'h0);
    chk("t2_c4_busy", {31'd0, rbusy[1]}, 32'h1);
`endif
    tick(); wb_valid = 1'b0; #1;
    chk("t2_c5_rd", rdata[63:32], 32'hDEADBEEF);
    chk("t2_c5_busy", {31'd0, rbusy[1]}, 32'h0);
    chk("t2_c5_err", {31'd0, err}, 32'h0);

    // saturation on r7, including one rejected allocation
    raddr = {5'd0, 5'd7}; alloc_valid = 1'b1; alloc_addr = 5'd7; #1;
    chk("t3_ready0", {31'd0, alloc_ready}, 32'h1);
    repeat (3) tick();
    #1 chk("t3_ready_full", {31'd0, alloc_ready}, 32'h0);
    tick();
    alloc_valid = 1'b0; #1;
    chk("t3_ready_hold", {31'd0, alloc_ready}, 32'h0);
    alloc_addr = 5'd8; #1;
    chk("t3_ready_r8", {31'd0, alloc_ready}, 32'h1);
    alloc_addr = 5'd7;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; tick();
    wb_valid = 1'b0; #1;
    chk("t3_ready_back", {31'd0, alloc_ready}, 32'h1);
    chk("t3_busy_wb1", {31'd0, rbusy[0]}, 32'h1);
    wb_valid = 1'b1; tick(); wb_valid = 1'b0; #1;
    chk("t3_busy_wb2", {31'd0, rbusy[0]}, 32'h1);
    wb_valid = 1'b1; tick(); wb_valid = 1'b0; #1;
    chk("t3_busy_wb3", {31'd0, rbusy[0]}, 32'h0);
    chk("t3_rd", rdata[31:0], 32'h77);
    chk("t3_err", {31'd0, err}, 32'h0);

    // same-cycle allocate and write back
    raddr = {5'd0, 5'd9}; alloc_valid = 1'b1; alloc_addr = 5'd9; tick();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h55; tick();
    alloc_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("t4_busy", {31'd0, rbusy[0]}, 32'h1);
    chk("t4_rd", rdata[31:0], 32'h55);
    chk("t4_err", {31'd0, err}, 32'h0);
    wb_valid = 1'b1; wb_data = 32'h56; tick(); wb_valid = 1'b0; #1;
    chk("t4_busy_done", {31'd0, rbusy[0]}, 32'h0);
    chk("t4_err_done", {31'd0, err}, 32'h0);
    alloc_valid = 1'b1; alloc_addr = 5'd10;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hAA; tick();
    alloc_valid = 1'b0; wb_valid = 1'b0; raddr = {5'd0, 5'd10}; #1;
    chk("t4_z_busy", {31'd0, rbusy[0]}, 32'h0);
    chk("t4_z_err", {31'd0, err}, 32'h0);
    chk("t4_z_rd", rdata[31:0], 32'hAA);

    // x0 and sticky error
    raddr = '0; alloc_valid = 1'b1; alloc_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF; #1;
    chk("t5_r0_ready", {31'd0, alloc_ready}, 32'h1);
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("t5_r0_rd", rdata[31:0], 32'h0);
    chk("t5_r0_busy", {30'd0, rbusy}, 32'h0);
    chk("t5_r0_err", {31'd0, err}, 32'h0);
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h1; tick();
    wb_valid = 1'b0; raddr = {5'd9, 5'd12}; #1;
    chk("t5_err_set", {31'd0, err}, 32'h1);
    chk("t5_r12_rd", rdata[31:0], 32'h1);
    chk("t5_r9_rd", rdata[63:32], 32'h56);
    repeat (3) tick();
    chk("t5_err_sticky", {31'd0, err}, 32'h1);
    rst = 1'b1; #1;
    chk("t5_err_clr", {31'd0, err}, 32'h0);
    tick(); rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_regfile_sb.md
# ysyx_20020207_regfile_sb

Parametrised integer register file with an integrated per-register write scoreboard, intended for the pipelined core. It provides NREAD combinational read ports and one write-back port. For each register it tracks a count of in-flight writes, and issue logic uses that count to detect RAW hazards. Register 0 is hardwired to zero and is never marked busy.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NREAD, 2, number of read ports.
- CNT_WIDTH, 2, width of the per-register pending-write counter; maximum outstanding writes per register is 2**CNT_WIDTH-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NREAD*ADDR_WIDTH  read addresses; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  read data, sliced the same way as raddr.
- rbusy  out  NREAD  port i's register has an outstanding write that is not yet visible.
- alloc_valid  in  1  issue reserves a destination register.
- alloc_addr  in  ADDR_WIDTH  register being reserved.
- alloc_ready  out  1  reservation can be accepted this cycle.
- wb_valid  in  1  write-back strobe.
- wb_addr  in  ADDR_WIDTH  write-back destination.
- wb_data  in  DATA_WIDTH  write-back value.
- err  out  1  sticky flag: write-back to a register whose pending count is 0.

## Operation
- **State.** The block holds `rf[2**ADDR_WIDTH]` (DATA_WIDTH bits each), `cnt[2**ADDR_WIDTH]` (CNT_WIDTH bits each) and `err`.
- **Reset.** While rst is high: all rf entries are 0, all cnt entries are 0, err is 0. So rdata reads 0, rbusy is 0, and alloc_ready is 1.
- **Allocation.**
  - Accepted when alloc_valid && alloc_ready.
  - `alloc_ready = (alloc_addr == 0) || (cnt[alloc_addr] != max)`.
  - An accepted allocation increments cnt[alloc_addr].
  - alloc_addr == 0 is always accepted and has no effect.
- **Write-back.** When wb_valid && wb_addr != 0:
  - rf[wb_addr] <= wb_data.
  - If cnt[wb_addr] != 0, the count decrements.
  - If cnt[wb_addr] == 0, the count stays 0 and err is set.
  - A write-back to address 0 is ignored completely.
- **Simultaneous allocation and write-back to the same nonzero register.** The count is unchanged; the data is still written.
  - If the count was 0, this is not an error: the allocation is counted first, so the net count stays 0 and err is not set.
  - alloc_ready is evaluated on the pre-update count.
- **Read.** `rdata[i] = rf[raddr[i]]`, with address 0 always returning 0. The bypass rule is given under Configuration.
- **Busy.** `rbusy[i] = (cnt[raddr[i]] != 0)`, with address 0 always 0. The bypass adjustment is given under Configuration.
- **err.** Sticky; only rst clears it.

## Timing
- Reads (rdata, rbusy) and alloc_ready are combinational from the current state and inputs. There are no registered outputs except err.
- Write-back data is visible on rdata the cycle after the wb_valid edge (without bypass).
- cnt changes on the clock edge after the allocation or write-back handshake.
- An allocation in cycle N makes rbusy high from cycle N+1 onward.
- A read in the same cycle as an allocation to the same address sees the old count.
- **Reset mid-operation.** All outstanding reservations are dropped, register contents are lost to 0, and err clears. rst is asynchronous, so outputs change without waiting for a clock edge.

## Configuration
- Macro: `YSYX_20020207_REGFILE_BYPASS_EN`.
- **Defined.** A same-cycle write-back is forwarded to the read ports:
  - If wb_valid && wb_addr == raddr[i] && wb_addr != 0, then rdata[i] = wb_data.
  - In that case rbusy[i] = (cnt[raddr[i]] > 1), i.e. the completing write no longer counts.
- **Undefined.** No forwarding:
  - rdata always reflects rf state.
  - rbusy stays high through the write-back cycle and clears the next cycle.

## Test plan
1. **Reset values.** Assert rst mid-run after writing r5 = 0x1234 and allocating r5. Required: rdata for r5 is 0, rbusy is 0, err is 0, alloc_ready is 1, with no clock edge needed.
2. **Allocate then write back.**
   - Sequence: allocate r3 (cycle 0); write back r3 = 0xDEADBEEF (cycle 4); read r3 on port 1.
   - Cycles 1-3: rbusy[1] is 1.
   - Cycle 4 with bypass: rdata = 0xDEADBEEF, rbusy = 0.
   - Cycle 4 without bypass: rdata = old value, rbusy = 1.
   - Cycle 5 (both builds): rdata = 0xDEADBEEF, rbusy = 0.
3. **Saturation (CNT_WIDTH=2).** Allocate r7 three times. Required: alloc_ready drops to 0 for r7 while it stays 1 for r8. One write-back to r7 raises alloc_ready for r7 again, and rbusy stays 1 until the third write-back.
4. **Same-cycle allocate and write back.** With cnt[r9]=1, allocate r9 and write back r9 = 0x55 in the same cycle. Required: count stays 1, rbusy stays 1, and rdata reads 0x55 the next cycle.
5. **x0 and error.**
   - Write back r0 = 0xFFFF and allocate r0. Required: r0 reads 0, rbusy is 0, err is 0.
   - Then write back r12 (count 0) = 0x1. Required: err rises the next cycle and stays high until rst; r12 reads 0x1.
